// File: rtl/select_biggest_reg_pkg.sv
// Shared sizing helpers for the registered maximum-selector.
package select_biggest_reg_pkg;

  // Index width never collapses to zero, even for a single way.
  function automatic int index_width(input int num_way);
    return (num_way > 1) ? $clog2(num_way) : 1;
  endfunction

  function automatic int tree_levels(input int num_way);
    return (num_way > 1) ? $clog2(num_way) : 0;
  endfunction

endpackage

// File: rtl/select_biggest_node.sv
// Two-input compare element: higher-index operand B wins only when strictly larger.
module select_biggest_node
  import select_biggest_reg_pkg::*;
#(
  parameter int VALUE_WIDTH = 4,
  parameter int INDEX_WIDTH = 4
) (
  input  logic [VALUE_WIDTH-1:0] a_value,
  input  logic [INDEX_WIDTH-1:0] a_index,
  input  logic                   a_valid,
  input  logic [VALUE_WIDTH-1:0] b_value,
  input  logic [INDEX_WIDTH-1:0] b_index,
  input  logic                   b_valid,
  output logic [VALUE_WIDTH-1:0] y_value,
  output logic [INDEX_WIDTH-1:0] y_index,
  output logic                   y_valid
);

  logic b_wins;

  // Strict compare keeps the lower index on ties.
  assign b_wins  = b_valid && (!a_valid || (b_value > a_value));
  assign y_value = b_wins ? b_value : a_value;
  assign y_index = b_wins ? b_index : a_index;
  assign y_valid = a_valid | b_valid;

endmodule

// File: rtl/select_biggest_reg.sv
// Registered largest-eligible-way selector: balanced compare tree plus one output register.
module select_biggest_reg
  import select_biggest_reg_pkg::*;
#(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_in,
  input  logic [NUM_WAY-1:0]                           condition_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]          select_out,
  output logic [index_width(NUM_WAY)-1:0]              select_index_out,
  output logic                                         select_valid_out
);

  localparam int W     = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int IW    = index_width(NUM_WAY);
  localparam int PAD   = 1 << tree_levels(NUM_WAY);
  localparam int NODES = 2 * PAD - 1;

  // Heap layout: node k has children 2k+1 (lower index) and 2k+2; leaves start at PAD-1.
  logic [W-1:0]  tree_value [NODES];
  logic [IW-1:0] tree_index [NODES];
  logic          tree_valid [NODES];

  genvar gi;
  generate
    for (gi = 0; gi < PAD; gi++) begin : g_leaf
      if (gi < NUM_WAY) begin : g_real
        assign tree_value[PAD-1+gi] = way_flatted_in[gi*W +: W];
        assign tree_valid[PAD-1+gi] = condition_in[gi];
      end else begin : g_pad
        assign tree_value[PAD-1+gi] = '0;
        assign tree_valid[PAD-1+gi] = 1'b0;
      end
      assign tree_index[PAD-1+gi] = IW'(gi);
    end

    for (gi = 0; gi < PAD - 1; gi++) begin : g_node
      select_biggest_node #(
        .VALUE_WIDTH(W),
        .INDEX_WIDTH(IW)
      ) u_node (
        .a_value(tree_value[2*gi+1]),
        .a_index(tree_index[2*gi+1]),
        .a_valid(tree_valid[2*gi+1]),
        .b_value(tree_value[2*gi+2]),
        .b_index(tree_index[2*gi+2]),
        .b_valid(tree_valid[2*gi+2]),
        .y_value(tree_value[gi]),
        .y_index(tree_index[gi]),
        .y_valid(tree_valid[gi])
      );
    end
  endgenerate

  logic [W-1:0]  select_reg, select_next;
  logic [IW-1:0] index_reg, index_next;
  logic          valid_reg, valid_next;

  // With nothing eligible the tree still carries a leaf value, so zero it here.
  always_comb begin
    valid_next  = tree_valid[0];
    select_next = '0;
    index_next  = '0;
    if (tree_valid[0]) begin
      select_next = tree_value[0];
      index_next  = tree_index[0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      select_reg <= '0;
      index_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      select_reg <= select_next;
      index_reg  <= index_next;
      valid_reg  <= valid_next;
    end
  end

  assign select_out       = select_reg;
  assign select_index_out = index_reg;
  assign select_valid_out = valid_reg;

endmodule

// File: tb/tb_select_biggest_reg.sv
// Scoreboard bench for select_biggest_reg: a 16x4 default instance and a 5x8 padded instance.
module tb_select_biggest_reg;

  typedef struct packed {
    logic [3:0] value;
    logic [3:0] index;
    logic       valid;
  } exp16_t;

  typedef struct packed {
    logic [7:0] value;
    logic [2:0] index;
    logic       valid;
  } exp5_t;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [63:0] way16 = '0;
  logic [15:0] cond16 = '0;
  logic [39:0] way5 = '0;
  logic [4:0]  cond5 = '0;

  logic [3:0]  sel16;
  logic [3:0]  idx16;
  logic        val16;
  logic [7:0]  sel5;
  logic [2:0]  idx5;
  logic        val5;

  exp16_t q16[$];
  exp5_t  q5[$];
  int     checks = 0;
  int     failures = 0;

  always #5 clk_in = ~clk_in;

  select_biggest_reg dut16 (
    .clk_in(clk_in), .reset_in(reset_in),
    .way_flatted_in(way16), .condition_in(cond16),
    .select_out(sel16), .select_index_out(idx16), .select_valid_out(val16)
  );

  select_biggest_reg #(.SINGLE_WAY_WIDTH_IN_BITS(8), .NUM_WAY(5)) dut5 (
    .clk_in(clk_in), .reset_in(reset_in),
    .way_flatted_in(way5), .condition_in(cond5),
    .select_out(sel5), .select_index_out(idx5), .select_valid_out(val5)
  );

  // Reference: scan eligible ways in ascending order, replace only on strictly larger.
  function automatic exp16_t model16(input logic rst, input logic [63:0] w, input logic [15:0] c);
    exp16_t e = '0;
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        if (c[i] && (!e.valid || w[i*4 +: 4] > e.value)) begin
          e.value = w[i*4 +: 4];
          e.index = 4'(i);
          e.valid = 1'b1;
        end
      end
    end
    return e;
  endfunction

  function automatic exp5_t model5(input logic rst, input logic [39:0] w, input logic [4:0] c);
    exp5_t e = '0;
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        if (c[i] && (!e.valid || w[i*8 +: 8] > e.value)) begin
          e.value = w[i*8 +: 8];
          e.index = 3'(i);
          e.valid = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // Drive one cycle of inputs; expectation is either the model result or a fixed required value.
  task automatic step(input logic rst, input logic [63:0] w16, input logic [15:0] c16,
                      input logic [39:0] w5, input logic [4:0] c5,
                      input logic fix16, input exp16_t req16,
                      input logic fix5, input exp5_t req5);
    @(posedge clk_in);
    #3;
    reset_in = rst;
    way16 = w16;
    cond16 = c16;
    way5 = w5;
    cond5 = c5;
    q16.push_back(fix16 ? req16 : model16(rst, w16, c16));
    q5.push_back(fix5 ? req5 : model5(rst, w5, c5));
  endtask

  always @(posedge clk_in) begin
    #1;
    if (q16.size() > 0) begin
      exp16_t e;
      e = q16.pop_front();
      checks++;
      $display("txn dut16 got %h/%0d/%b exp %h/%0d/%b", sel16, idx16, val16, e.value, e.index, e.valid);
      if (sel16 !== e.value || idx16 !== e.index || val16 !== e.valid) begin
        failures++;
        $display("FAIL dut16_result got value=%h index=%0d valid=%b required value=%h index=%0d valid=%b",
                 sel16, idx16, val16, e.value, e.index, e.valid);
      end
    end
    if (q5.size() > 0) begin
      exp5_t e;
      e = q5.pop_front();
      checks++;
      $display("txn dut5 got %h/%0d/%b exp %h/%0d/%b", sel5, idx5, val5, e.value, e.index, e.valid);
      if (sel5 !== e.value || idx5 !== e.index || val5 !== e.valid) begin
        failures++;
        $display("FAIL dut5_result got value=%h index=%0d valid=%b required value=%h index=%0d valid=%b",
                 sel5, idx5, val5, e.value, e.index, e.valid);
      end
    end
  end

  function automatic logic [63:0] rand_ways16(input int mode);
    logic [63:0] w;
    for (int i = 0; i < 16; i++)
      w[i*4 +: 4] = (mode == 0) ? 4'($urandom) : 4'($urandom_range(13, 15));
    return w;
  endfunction

  function automatic logic [15:0] rand_cond16(input int mode);
    case (mode)
      0: return 16'($urandom);
      1: return 16'($urandom & $urandom & $urandom);
      2: return 16'h0000;
      default: return 16'hffff;
    endcase
  endfunction

  initial begin
    logic [63:0] w;
    logic [39:0] w5v;
    exp16_t zero16;
    exp5_t  zero5;
    zero16 = '0;
    zero5 = '0;

    // Reset state
    step(1'b1, {$urandom, $urandom}, 16'hffff, 40'hff_ffff_ffff, 5'h1f, 1'b1, zero16, 1'b1, zero5);
    step(1'b1, {$urandom, $urandom}, 16'h1234, 40'h12_3456_789a, 5'h0a, 1'b1, zero16, 1'b1, zero5);

    // Masked maximum; padded 5-way instance
    step(1'b0, {4'ha,4'hb,4'hc,4'hd,4'h5,4'h2,4'h3,4'h4,4'h5,4'h2,4'h3,4'h4,4'ha,4'hb,4'ha,4'h5},
         16'b1110_0111_1110_0111, {8'h01, 8'hff, 8'h80, 8'hff, 8'h10}, 5'b10101,
         1'b1, '{value: 4'hc, index: 4'd13, valid: 1'b1},
         1'b1, '{value: 8'h80, index: 3'd2, valid: 1'b1});
    step(1'b0, {4'h5,4'h8,4'h7,4'hc,4'h2,4'h9,4'h3,4'h4,4'h2,4'h9,4'h3,4'h4,4'h5,4'h8,4'h7,4'ha},
         16'b1011_0111_1111_1111, {8'h01, 8'hff, 8'h80, 8'hff, 8'h10}, 5'b11111,
         1'b1, '{value: 4'hc, index: 4'd12, valid: 1'b1},
         1'b1, '{value: 8'hff, index: 3'd1, valid: 1'b1});

    // Tie between ways 3 and 9: lowest index wins
    w = 64'h1111_1111_1111_1111;
    w[3*4 +: 4] = 4'hf;
    w[9*4 +: 4] = 4'hf;
    step(1'b0, w, 16'hffff, {8'h01, 8'h07, 8'h07, 8'h02, 8'h07}, 5'b11111,
         1'b1, '{value: 4'hf, index: 4'd3, valid: 1'b1},
         1'b1, '{value: 8'h07, index: 3'd0, valid: 1'b1});

    // Nothing eligible
    step(1'b0, {$urandom, $urandom}, 16'h0000, {8'hff, $urandom}, 5'b00000,
         1'b1, zero16, 1'b1, zero5);

    // Reset over a registered nonzero result, then recovery on the next edge
    step(1'b0, 64'h0000_0000_0009_0000, 16'h0010, 40'h00_0000_4200, 5'b00010,
         1'b1, '{value: 4'h9, index: 4'd4, valid: 1'b1},
         1'b1, '{value: 8'h42, index: 3'd1, valid: 1'b1});
    step(1'b1, 64'h0000_0000_0009_0000, 16'h0010, 40'h00_0000_4200, 5'b00010,
         1'b1, zero16, 1'b1, zero5);
    step(1'b0, 64'h7000_0000_0000_0000, 16'h8000, 40'h33_0000_0000, 5'b10000,
         1'b1, '{value: 4'h7, index: 4'd15, valid: 1'b1},
         1'b1, '{value: 8'h33, index: 3'd4, valid: 1'b1});

    // Back-to-back random traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      w5v = {8'($urandom), $urandom};
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < 5; i++) w5v[i*8 +: 8] = 8'($urandom_range(250, 255));
      step($urandom_range(0, 49) == 0,
           rand_ways16(int'($urandom_range(0, 1))), rand_cond16(int'($urandom_range(0, 3))),
           w5v, 5'($urandom), 1'b0, zero16, 1'b0, zero5);
    end

    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    checks++;
    if (q16.size() != 0 || q5.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d required pending=0", q16.size() + q5.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
